alu_seq: RTL and testbench

Multi-byte operation sequencer that drives the 8-bit combinational ALU. It is the initiator side of the ALU port set (`opt`/`numa`/`numb`/`ci` out, `s`/`zero`/`co` in). It accepts one wide operation per valid/ready handshake and issues it to the ALU one byte per cycle, chaining carry or borrow between bytes. It returns the assembled wide result and flags to the calculator controller.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_seq_mul.sv | 53 +++++
 rtl/alu_seq.sv | 198 +++++++++++++++++++
 tb/tb_alu_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU, the multi-byte sequencer and the
// calculator controller: opcode encodings and the sequencer state encoding.
package alu_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Opcodes that are walked byte by byte through the ALU.
  function automatic logic is_run_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // Opcodes whose carry/borrow is chained from one byte into the next.
  function automatic logic is_chain_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add multiply helper for alu_seq (built only with ALU_SEQ_MUL_EN).
// Holds the multiplicand, the shifting multiplier, the low product byte and
// an 8-iteration down-counter. The high accumulator byte lives in the
// sequencer's registered ALU operand, so this block only supplies the
// operands for the next iteration and the final product.
module alu_seq_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_active,
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  input  logic [7:0]  i_alu_s,
  input  logic        i_alu_co,
  output logic        o_last,
  output logic [7:0]  o_numa_nxt,
  output logic [7:0]  o_numb_nxt,
  output logic [15:0] o_prod_nxt
);

  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_lo;
  logic [2:0] r_cnt;

  // Load operands on start, then shift one multiplier bit per iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_lo  <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_lo  <= '0;
      r_cnt <= 3'd7;
    end else if (i_active) begin
      r_lo  <= {i_alu_s[0], r_lo[7:1]};
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt - 3'd1;
    end
  end

  // Next-iteration operands and the product as it stands after this add.
  always_comb begin
    o_last     = (r_cnt == 3'd0);
    o_numa_nxt = {i_alu_co, i_alu_s[7:1]};
    o_numb_nxt = r_b[1] ? r_a : 8'h00;
    o_prod_nxt = {i_alu_co, i_alu_s, r_lo[7:1]};
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-byte operation sequencer driving the 8-bit combinational ALU.
// Optional multiply support is enabled by defining ALU_SEQ_MUL_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; ALU port driven to zero
// RUN   | one operand byte per cycle on the ALU, carry/borrow chained
// MUL   | 8 shift-add iterations using ALU ADD (ALU_SEQ_MUL_EN only)
// DONE  | result held on out_* until out_ready
module alu_seq
  import alu_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_opt,
  input  logic [8*NBYTES-1:0] in_a,
  input  logic [8*NBYTES-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_s,
  output logic                out_zero,
  output logic                out_co,
  output logic                out_err,
  output logic [2:0]          alu_opt,
  output logic [7:0]          alu_numa,
  output logic [7:0]          alu_numb,
  output logic                alu_ci,
  input  logic [7:0]          alu_s,
  input  logic                alu_zero,
  input  logic                alu_co
);

  localparam int W = 8 * NBYTES;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_s;
  logic [2:0]   r_opt;
  logic [1:0]   r_kleft;
  logic         r_co;
  logic         r_err;
  logic         w_accept;
  logic         w_run_last;
  logic         w_mul_last;
  // Zero is derived from the assembled result, so the ALU's flag is not needed.
  logic         w_unused;

  assign w_unused   = alu_zero;
  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_run_last = (r_kleft == 2'd0);

`ifdef ALU_SEQ_MUL_EN
  logic [7:0]  w_mul_numa;
  logic [7:0]  w_mul_numb;
  logic [15:0] w_mul_prod;

  alu_seq_mul u_mul (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_accept && (in_opt == OP_MUL)),
    .i_active   (r_state == ST_MUL),
    .i_a        (in_a[7:0]),
    .i_b        (in_b[7:0]),
    .i_alu_s    (alu_s),
    .i_alu_co   (alu_co),
    .o_last     (w_mul_last),
    .o_numa_nxt (w_mul_numa),
    .o_numb_nxt (w_mul_numb),
    .o_prod_nxt (w_mul_prod)
  );
`else
  assign w_mul_last = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_run_op(in_opt)) w_state_nxt = ST_RUN;
`ifdef ALU_SEQ_MUL_EN
          else if (in_opt == OP_MUL) w_state_nxt = ST_MUL;
`endif
          else w_state_nxt = ST_DONE;
        end
      end
      ST_RUN:  if (w_run_last) w_state_nxt = ST_DONE;
      ST_MUL:  if (w_mul_last) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs; result registers feed out_* directly.
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
    out_zero  = (r_state == ST_DONE) && (r_s == '0);
    out_s     = r_s;
    out_co    = r_co;
    out_err   = r_err;
  end

  // Datapath: operand shift registers, result assembly and the registered
  // ALU port. Each ALU operand is loaded one edge ahead of the cycle it is
  // used, so the byte in flight's carry feeds the next byte's ci directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_s      <= '0;
      r_opt    <= OP_NOP;
      r_kleft  <= '0;
      r_co     <= 1'b0;
      r_err    <= 1'b0;
      alu_opt  <= OP_NOP;
      alu_numa <= '0;
      alu_numb <= '0;
      alu_ci   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_opt   <= in_opt;
            r_a     <= in_a >> 8;
            r_b     <= in_b >> 8;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_err   <= 1'b1;
            r_kleft <= 2'(NBYTES - 1);
            if (is_run_op(in_opt)) begin
              r_err    <= 1'b0;
              alu_opt  <= in_opt;
              alu_numa <= in_a[7:0];
              alu_numb <= in_b[7:0];
              alu_ci   <= 1'b0;
            end
`ifdef ALU_SEQ_MUL_EN
            else if (in_opt == OP_MUL) begin
              r_err    <= 1'b0;
              alu_opt  <= OP_ADD;
              alu_numa <= 8'h00;
              alu_numb <= in_b[0] ? in_a[7:0] : 8'h00;
              alu_ci   <= 1'b0;
            end
`endif
          end
        end
        ST_RUN: begin
          r_s  <= {alu_s, r_s[W-1:8]};
          r_co <= is_chain_op(r_opt) ? alu_co : 1'b0;
          r_a  <= r_a >> 8;
          r_b  <= r_b >> 8;
          if (w_run_last) begin
            alu_opt  <= OP_NOP;
            alu_numa <= '0;
            alu_numb <= '0;
            alu_ci   <= 1'b0;
          end else begin
            alu_numa <= r_a[7:0];
            alu_numb <= r_b[7:0];
            alu_ci   <= is_chain_op(r_opt) ? alu_co : 1'b0;
            r_kleft  <= r_kleft - 2'd1;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        ST_MUL: begin
          if (w_mul_last) begin
            r_s      <= W'(w_mul_prod);
            alu_opt  <= OP_NOP;
            alu_numa <= '0;
            alu_numb <= '0;
            alu_ci   <= 1'b0;
          end else begin
            alu_numa <= w_mul_numa;
            alu_numb <= w_mul_numb;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural 8-bit ALU on its ALU port.
// Expected results are queued when an operation is issued and popped when
// out_valid appears. Multiply expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int NB = 2;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_opt = 3'd0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_s;
  logic         out_zero, out_co, out_err;
  logic [2:0]   alu_opt;
  logic [7:0]   alu_numa, alu_numb, alu_s;
  logic         alu_ci, alu_zero, alu_co;

  always #5 clk = ~clk;

  alu_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opt(in_opt),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_zero(out_zero), .out_co(out_co), .out_err(out_err),
    .alu_opt(alu_opt), .alu_numa(alu_numa), .alu_numb(alu_numb),
    .alu_ci(alu_ci), .alu_s(alu_s), .alu_zero(alu_zero), .alu_co(alu_co)
  );

  // Behavioural 8-bit ALU; for SUB ci is borrow-in and co is borrow-out.
  logic [8:0] alu_r;
  always_comb begin
    alu_r = 9'h000;
    case (alu_opt)
      OP_ADD: alu_r = {1'b0, alu_numa} + {1'b0, alu_numb} + {8'h00, alu_ci};
      OP_SUB: alu_r = {1'b0, alu_numa} - {1'b0, alu_numb} - {8'h00, alu_ci};
      OP_AND: alu_r = {1'b0, alu_numa & alu_numb};
      OP_OR:  alu_r = {1'b0, alu_numa | alu_numb};
      default: alu_r = 9'h000;
    endcase
  end
  assign alu_s    = alu_r[7:0];
  assign alu_co   = alu_r[8];
  assign alu_zero = (alu_r[7:0] == 8'h00);

  typedef struct {
    logic [W-1:0] s;
    logic         zero;
    logic         co;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] s, input logic co, input logic err, input int lat);
    exp_t e;
    e.s = s; e.zero = (s == '0); e.co = co; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  // Issue one request and wait (bounded) for the result.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    int   cyc;
    exp_t e;
    chk({tag, ".in_ready"}, W'(in_ready), W'(1));
    in_valid = 1'b1; in_opt = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    chk({tag, ".lat"},  W'(cyc),      W'(e.lat));
    chk({tag, ".s"},    out_s,        e.s);
    chk({tag, ".zero"}, W'(out_zero), W'(e.zero));
    chk({tag, ".co"},   W'(out_co),   W'(e.co));
    chk({tag, ".err"},  W'(out_err),  W'(e.err));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".rel_in_ready"},  W'(in_ready),  W'(1));
    chk({tag, ".rel_out_valid"}, W'(out_valid), W'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W:0]   rr;
    logic [2:0]   rop;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.in_ready",  W'(in_ready),  W'(1));
    chk("rst.out_valid", W'(out_valid), W'(0));
    chk("rst.out_s",     out_s,         '0);
    chk("rst.out_zero",  W'(out_zero),  W'(0));
    chk("rst.out_co",    W'(out_co),    W'(0));
    chk("rst.out_err",   W'(out_err),   W'(0));
    chk("rst.alu_opt",   W'(alu_opt),   W'(0));
    chk("rst.alu_numa",  W'(alu_numa),  W'(0));
    chk("rst.alu_numb",  W'(alu_numb),  W'(0));
    chk("rst.alu_ci",    W'(alu_ci),    W'(0));

    push(16'h0100, 1'b0, 1'b0, NB + 1);
    run_op("add_ff_1", OP_ADD, 16'h00FF, 16'h0001); release_result("add_ff_1");
    push(16'hFFFF, 1'b1, 1'b0, NB + 1);
    run_op("sub_5_6", OP_SUB, 16'h0005, 16'h0006); release_result("sub_5_6");
    push(16'h0000, 1'b0, 1'b0, NB + 1);
    run_op("sub_eq", OP_SUB, 16'h1234, 16'h1234); release_result("sub_eq");
    push(16'h0000, 1'b0, 1'b0, NB + 1);
    run_op("and", OP_AND, 16'h5555, 16'hAAAA); release_result("and");
    push(16'hFFFF, 1'b0, 1'b0, NB + 1);
    run_op("or", OP_OR, 16'h5555, 16'hAAAA); release_result("or");

`ifdef ALU_SEQ_MUL_EN
    push(16'h0204, 1'b0, 1'b0, 9);
    run_op("mul_172_3", OP_MUL, 16'd172, 16'd3); release_result("mul_172_3");
    push(16'h1440, 1'b0, 1'b0, 9);
    run_op("mul_96_54", OP_MUL, 16'd96, 16'd54); release_result("mul_96_54");
`else
    push(16'h0000, 1'b0, 1'b1, 1);
    run_op("mul_off", OP_MUL, 16'd172, 16'd3); release_result("mul_off");
`endif

    // Leave a carry behind so the error result's co is meaningfully cleared.
    push(16'h0000, 1'b1, 1'b0, NB + 1);
    run_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001); release_result("add_wrap");
    push(16'h0000, 1'b0, 1'b1, 1);
    run_op("op7", 3'd7, 16'h1111, 16'h2222); release_result("op7");
    push(16'h0000, 1'b0, 1'b1, 1);
    run_op("nop", OP_NOP, 16'h1111, 16'h2222); release_result("nop");

    for (int i = 0; i < 6; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = (i % 2 == 0) ? OP_ADD : OP_SUB;
      rr  = (rop == OP_ADD) ? ({1'b0, ra} + {1'b0, rb}) : ({1'b0, ra} - {1'b0, rb});
      push(rr[W-1:0], rr[W], 1'b0, NB + 1);
      run_op("rand", rop, ra, rb); release_result("rand");
    end

    // Backpressure: result held, no second request taken.
    push(16'h5555, 1'b0, 1'b0, NB + 1);
    run_op("bp", OP_ADD, 16'h1234, 16'h4321);
    in_valid = 1'b1; in_opt = OP_OR; in_a = 16'hF0F0; in_b = 16'h0F0F;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.out_s",     out_s,         16'h5555);
      chk("bp.out_valid", W'(out_valid), W'(1));
      chk("bp.in_ready",  W'(in_ready),  W'(0));
      chk("bp.out_zero",  W'(out_zero),  W'(0));
    end
    in_valid = 1'b0;
    release_result("bp");
    @(posedge clk); #1;
    chk("bp.idle_after", W'(in_ready), W'(1));

    // Reset while byte 1 is on the ALU.
    in_valid = 1'b1; in_opt = OP_ADD; in_a = 16'h0102; in_b = 16'h0304;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort.byte0_numa", W'(alu_numa), W'(8'h02));
    @(posedge clk); #1;
    chk("abort.byte1_numa", W'(alu_numa), W'(8'h01));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.in_ready",  W'(in_ready),  W'(1));
    chk("abort.out_valid", W'(out_valid), W'(0));
    chk("abort.alu_opt",   W'(alu_opt),   W'(0));
    chk("abort.alu_numa",  W'(alu_numa),  W'(0));
    chk("abort.alu_numb",  W'(alu_numb),  W'(0));
    chk("abort.alu_ci",    W'(alu_ci),    W'(0));
    push(16'h1000, 1'b0, 1'b0, NB + 1);
    run_op("post_abort", OP_ADD, 16'h0F0F, 16'h00F1); release_result("post_abort");

    chk("sb_empty", W'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
